// File: rtl/uart_rx_8n1_if.sv
// Consumer-side bus of the 8N1 UART receiver: received byte, valid/ack
// handshake and the two status flags.
interface uart_rx_8n1_if;
   localparam int unsigned BYTE_W = 8;

   logic              rxack;
   logic [BYTE_W-1:0] rxbyte;
   logic              rxvalid;
   logic              rxerror;
   logic              overrun;

   modport master (
      input  rxack,
      output rxbyte,
      output rxvalid,
      output rxerror,
      output overrun
   );

   modport slave (
      output rxack,
      input  rxbyte,
      input  rxvalid,
      input  rxerror,
      input  overrun
   );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with a one-byte holding register, valid/ack handshake,
// framing-error pulse, sticky overrun flag and break handling.
// Optional build macro UART_RX_MAJORITY_EN: every bit sample becomes the
// 2-of-3 vote of the synchronized line around the sample edge.
module uart_rx_8n1 #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          rx,
   uart_rx_8n1_if.master bus
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned IDX_W  = 3;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTE_W - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   logic              sync1;
   logic              sync2;
   logic              rx_s;
   logic              sample_c;
   logic [1:0]        settle;
   logic              armed;

   logic [2:0]        state;
   logic [2:0]        state_d;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_d;
   logic [IDX_W-1:0]  bit_idx;
   logic [IDX_W-1:0]  bit_idx_d;
   logic [BYTE_W-1:0] shift;
   logic [BYTE_W-1:0] shift_d;
   logic              done_c;
   logic              ferr_c;

   // Two-flop synchronizer for the asynchronous serial line (idle high).
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= rx;
         sync2 <= sync1;
      end
   end

   assign rx_s = sync2;

`ifdef UART_RX_MAJORITY_EN
   logic sync3;

   // One-edge-old copy of rx_s, the earliest tap of the vote window.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync3 <= 1'b1;
      end else begin
         sync3 <= sync2;
      end
   end

   // Vote over rx_s one edge before, at, and one edge after the sample edge;
   // sync1 is exactly the value rx_s takes on at the following edge.
   assign sample_c = (sync3 & sync2) | (sync3 & sync1) | (sync2 & sync1);
`else
   assign sample_c = rx_s;
`endif

   // The synchronizer shows its reset value for two edges after reset; only
   // arm start detection once it carries the real line and that line is high,
   // so a frame cut by reset cannot be picked up halfway through.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         settle <= 2'd0;
         armed  <= 1'b0;
      end else begin
         if (settle != 2'd2) begin
            settle <= settle + 2'd1;
         end
         if ((settle == 2'd2) && rx_s) begin
            armed <= 1'b1;
         end
      end
   end

   // Receiver state, bit-timing counter, bit index and shift register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         bit_idx <= bit_idx_d;
         shift   <= shift_d;
      end
   end

   // Next-state logic: half a bit to the start-bit centre, then one bit
   // period per data/stop sample.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt + CNT_W'(1);
      bit_idx_d = bit_idx;
      shift_d   = shift;
      done_c    = 1'b0;
      ferr_c    = 1'b0;

      case (state)
         ST_IDLE: begin
            cnt_d     = '0;
            bit_idx_d = '0;
            if (armed && !rx_s) begin
               state_d = ST_START;
            end
         end

         ST_START: begin
            if (cnt == HALF_LAST) begin
               cnt_d = '0;
               if (!sample_c) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_d     = '0;
               shift_d   = {sample_c, shift[BYTE_W-1:1]};
               bit_idx_d = bit_idx + IDX_W'(1);
               if (bit_idx == IDX_LAST) begin
                  state_d = ST_STOP;
               end
            end
         end

         ST_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_d = '0;
               if (sample_c) begin
                  done_c  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ferr_c  = 1'b1;
                  state_d = ST_BREAK;
               end
            end
         end

         ST_BREAK: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Holding register and handshake: a completing byte always wins over an
   // ack on the same edge; overrun marks a byte lost without an ack.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         bus.rxbyte  <= '0;
         bus.rxvalid <= 1'b0;
         bus.rxerror <= 1'b0;
         bus.overrun <= 1'b0;
      end else begin
         bus.rxerror <= ferr_c;
         if (done_c) begin
            bus.rxbyte  <= shift;
            bus.rxvalid <= 1'b1;
            if (bus.rxvalid) begin
               bus.overrun <= !bus.rxack;
            end
         end else if (bus.rxvalid && bus.rxack) begin
            bus.rxvalid <= 1'b0;
            bus.overrun <= 1'b0;
         end
      end
   end

endmodule
